// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I sequencing FSM: FETCH/DECODE/EXEC/MEM/WB with trap on illegal
// opcode or data-memory timeout, plus a retired-instruction counter.
module multicycle_controller #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    input  logic             trap_clear,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic             alu_src,
    output logic [1:0]       alu_op,
    output logic             mem_read,
    output logic             mem_write,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             trap,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired
);

    localparam int unsigned WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd7
    } state_t;

    state_t            state_q, state_d;
    logic [6:0]        op_q;
    logic [WAIT_W-1:0] wait_q;
    logic [CNT_W-1:0]  cnt_q;

    logic       ir_write_c, pc_write_c, pc_src_c, alu_src_c;
    logic [1:0] alu_op_c;
    logic       mem_read_c, mem_write_c, mem_to_reg_c, reg_write_c, trap_c;

    // State, latched opcode, MEM wait counter and retired counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            op_q    <= 7'd0;
            wait_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_FETCH) op_q <= opcode;
            wait_q  <= (state_q == S_MEM && state_d == S_MEM) ? wait_q + WAIT_W'(1) : '0;
            if (pc_write_c) cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Next state and strobes, decoded from state_q and the latched opcode
    always_comb begin
        state_d      = state_q;
        ir_write_c   = 1'b0;
        pc_write_c   = 1'b0;
        pc_src_c     = 1'b0;
        alu_src_c    = 1'b0;
        alu_op_c     = 2'b00;
        mem_read_c   = 1'b0;
        mem_write_c  = 1'b0;
        mem_to_reg_c = 1'b0;
        reg_write_c  = 1'b0;
        trap_c       = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_write_c = 1'b1;
                state_d    = S_DECODE;
            end
            S_DECODE: begin
                case (op_q)
                    OP_R, OP_I, OP_LD, OP_ST, OP_BR: state_d = S_EXEC;
                    default:                         state_d = S_TRAP;
                endcase
            end
            S_EXEC: begin
                case (op_q)
                    OP_R: begin
                        alu_op_c = 2'b10;
                        state_d  = S_WB;
                    end
                    OP_I: begin
                        alu_op_c  = 2'b11;
                        alu_src_c = 1'b1;
                        state_d   = S_WB;
                    end
                    OP_LD, OP_ST: begin
                        alu_src_c = 1'b1;
                        state_d   = S_MEM;
                    end
                    OP_BR: begin
                        alu_op_c   = 2'b01;
                        pc_write_c = 1'b1;
                        pc_src_c   = zero;
                        state_d    = S_FETCH;
                    end
                    default: state_d = S_TRAP;
                endcase
            end
            S_MEM: begin
                alu_src_c = 1'b1;
                if (op_q == OP_LD) mem_read_c  = 1'b1;
                else               mem_write_c = 1'b1;
                if (mem_ready) begin
                    if (op_q == OP_LD) begin
                        state_d = S_WB;
                    end else begin
                        pc_write_c = 1'b1;
                        state_d    = S_FETCH;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_TRAP;
                end
            end
            S_WB: begin
                reg_write_c = 1'b1;
                pc_write_c  = 1'b1;
                state_d     = S_FETCH;
                case (op_q)
                    OP_R:  alu_op_c = 2'b10;
                    OP_I: begin
                        alu_op_c  = 2'b11;
                        alu_src_c = 1'b1;
                    end
                    default: begin
                        alu_src_c    = 1'b1;
                        mem_to_reg_c = 1'b1;
                    end
                endcase
            end
            S_TRAP: begin
                trap_c = 1'b1;
                if (trap_clear) state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Reset forces every visible output to zero in the same cycle
    assign ir_write   = ir_write_c   & ~reset;
    assign pc_write   = pc_write_c   & ~reset;
    assign pc_src     = pc_src_c     & ~reset;
    assign alu_src    = alu_src_c    & ~reset;
    assign alu_op     = reset ? 2'b00 : alu_op_c;
    assign mem_read   = mem_read_c   & ~reset;
    assign mem_write  = mem_write_c  & ~reset;
    assign mem_to_reg = mem_to_reg_c & ~reset;
    assign reg_write  = reg_write_c  & ~reset;
    assign trap       = trap_c       & ~reset;
    assign state      = reset ? 3'd0 : state_q;
    assign retired    = reset ? '0 : cnt_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed self-checking bench for multicycle_controller: per-cycle expected strobe
// vectors for each instruction class, trap paths and mid-instruction reset.
module tb_multicycle_controller;

    localparam int unsigned MEM_TIMEOUT = 15;
    localparam int unsigned CNT_W       = 32;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    localparam logic [2:0] S_F = 3'd0, S_D = 3'd1, S_E = 3'd2, S_M = 3'd3, S_W = 3'd4, S_T = 3'd7;

    logic             clk = 1'b0;
    logic             reset, zero, mem_ready, trap_clear;
    logic [6:0]       opcode;
    logic             ir_write, pc_write, pc_src, alu_src, mem_read, mem_write;
    logic             mem_to_reg, reg_write, trap;
    logic [1:0]       alu_op;
    logic [2:0]       state;
    logic [CNT_W-1:0] retired;
    logic [13:0]      obs;

    int checks = 0;
    int errors = 0;
    logic [CNT_W-1:0] exp_ret = '0;

    multicycle_controller #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .trap_clear(trap_clear), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
        .alu_src(alu_src), .alu_op(alu_op), .mem_read(mem_read), .mem_write(mem_write),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .trap(trap), .state(state),
        .retired(retired)
    );

    always #5 clk = ~clk;

    assign obs = {ir_write, pc_write, pc_src, alu_src, alu_op, mem_read, mem_write,
                  mem_to_reg, reg_write, trap, state};

    // Expected output vector in the same field order as obs
    function automatic logic [13:0] ev(input logic ir, input logic pw, input logic ps,
                                       input logic as, input logic [1:0] ao, input logic mr,
                                       input logic mw, input logic m2r, input logic rw,
                                       input logic tr, input logic [2:0] st);
        return {ir, pw, ps, as, ao, mr, mw, m2r, rw, tr, st};
    endfunction

    function automatic logic [13:0] ev_fetch();
        return ev(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, S_F);
    endfunction

    function automatic logic [13:0] ev_decode();
        return ev(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, S_D);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; opcode = OP_R; zero = 1'b0; mem_ready = 1'b0; trap_clear = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        if (obs !== 14'd0) begin
            $display("FAIL reset_outputs: got %b expected %b", obs, 14'd0); errors++;
        end
        checks++;
        if (retired !== '0) begin
            $display("FAIL reset_retired: got %0d expected 0", retired); errors++;
        end
        checks++;
        reset = 1'b0;
        #1;
        if (obs !== ev_fetch()) begin
            $display("FAIL reset_release_fetch: got %b expected %b", obs, ev_fetch()); errors++;
        end
        checks++;
    endtask

    task automatic test_rtype();
        logic [13:0] e[$];
        e = {ev_fetch(), ev_decode(), ev(0, 0, 0, 0, 2'b10, 0, 0, 0, 0, 0, S_E),
             ev(0, 1, 0, 0, 2'b10, 0, 0, 0, 1, 0, S_W)};
        opcode = OP_R; mem_ready = 1'b1;
        for (int i = 0; i < e.size(); i++) begin
            #1;
            if (obs !== e[i]) begin
                $display("FAIL rtype[%0d]: got %b expected %b", i, obs, e[i]); errors++;
            end
            checks++;
            step();
        end
        exp_ret = exp_ret + CNT_W'(1);
        if (retired !== exp_ret || state !== S_F) begin
            $display("FAIL rtype_retired: got %0d/state %0d expected %0d/state 0", retired, state, exp_ret);
            errors++;
        end
        checks++;
    endtask

    task automatic test_branch();
        logic [13:0] e[$];
        for (int z = 1; z >= 0; z--) begin
            e = {ev_fetch(), ev_decode(), ev(0, 1, z[0], 0, 2'b01, 0, 0, 0, 0, 0, S_E)};
            opcode = OP_BR; zero = z[0]; mem_ready = 1'b0;
            for (int i = 0; i < e.size(); i++) begin
                #1;
                if (obs !== e[i]) begin
                    $display("FAIL branch_z%0d[%0d]: got %b expected %b", z, i, obs, e[i]); errors++;
                end
                checks++;
                step();
            end
            exp_ret = exp_ret + CNT_W'(1);
            if (retired !== exp_ret || state !== S_F) begin
                $display("FAIL branch_z%0d_retired: got %0d/state %0d expected %0d/state 0", z, retired, state, exp_ret);
                errors++;
            end
            checks++;
        end
        zero = 1'b0;
    endtask

    task automatic test_load();
        logic [13:0] e[$];
        logic        rdy[$];
        e   = {ev_fetch(), ev_decode(), ev(0, 0, 0, 1, 2'b00, 0, 0, 0, 0, 0, S_E)};
        rdy = {1'b0, 1'b0, 1'b0};
        for (int k = 0; k < 4; k++) begin
            e.push_back(ev(0, 0, 0, 1, 2'b00, 1, 0, 0, 0, 0, S_M));
            rdy.push_back(k == 3);
        end
        e.push_back(ev(0, 1, 0, 1, 2'b00, 0, 0, 1, 1, 0, S_W));
        rdy.push_back(1'b0);
        opcode = OP_LD;
        for (int i = 0; i < e.size(); i++) begin
            mem_ready = rdy[i];
            #1;
            if (obs !== e[i]) begin
                $display("FAIL load[%0d]: got %b expected %b", i, obs, e[i]); errors++;
            end
            checks++;
            step();
        end
        exp_ret = exp_ret + CNT_W'(1);
        if (retired !== exp_ret || state !== S_F) begin
            $display("FAIL load_retired: got %0d/state %0d expected %0d/state 0", retired, state, exp_ret);
            errors++;
        end
        checks++;
    endtask

    task automatic test_itype_store();
        logic [13:0] e[$];
        logic        rdy[$];
        logic [6:0]  ops[$];
        e   = {ev_fetch(), ev_decode(), ev(0, 0, 0, 1, 2'b11, 0, 0, 0, 0, 0, S_E),
               ev(0, 1, 0, 1, 2'b11, 0, 0, 0, 1, 0, S_W),
               ev_fetch(), ev_decode(), ev(0, 0, 0, 1, 2'b00, 0, 0, 0, 0, 0, S_E),
               ev(0, 0, 0, 1, 2'b00, 0, 1, 0, 0, 0, S_M),
               ev(0, 1, 0, 1, 2'b00, 0, 1, 0, 0, 0, S_M)};
        rdy = {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        ops = {OP_I, OP_I, OP_I, OP_I, OP_ST, OP_ST, OP_ST, OP_ST, OP_ST};
        for (int i = 0; i < e.size(); i++) begin
            mem_ready = rdy[i]; opcode = ops[i];
            #1;
            if (obs !== e[i]) begin
                $display("FAIL itype_store[%0d]: got %b expected %b", i, obs, e[i]); errors++;
            end
            checks++;
            step();
        end
        exp_ret = exp_ret + CNT_W'(2);
        if (retired !== exp_ret || state !== S_F) begin
            $display("FAIL itype_store_retired: got %0d/state %0d expected %0d/state 0", retired, state, exp_ret);
            errors++;
        end
        checks++;
    endtask

    task automatic test_store_timeout();
        logic [13:0] e[$];
        logic [13:0] e_trap;
        e_trap = ev(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, S_T);
        e = {ev_fetch(), ev_decode(), ev(0, 0, 0, 1, 2'b00, 0, 0, 0, 0, 0, S_E)};
        for (int k = 0; k < int'(MEM_TIMEOUT); k++) e.push_back(ev(0, 0, 0, 1, 2'b00, 0, 1, 0, 0, 0, S_M));
        e.push_back(e_trap);
        e.push_back(e_trap);
        opcode = OP_ST; mem_ready = 1'b0; trap_clear = 1'b0;
        for (int i = 0; i < e.size(); i++) begin
            #1;
            if (obs !== e[i]) begin
                $display("FAIL st_timeout[%0d]: got %b expected %b", i, obs, e[i]); errors++;
            end
            checks++;
            step();
        end
        if (retired !== exp_ret) begin
            $display("FAIL st_timeout_retired: got %0d expected %0d", retired, exp_ret); errors++;
        end
        checks++;
        trap_clear = 1'b1;
        #1;
        if (obs !== e_trap) begin
            $display("FAIL st_timeout_clear_cycle: got %b expected %b", obs, e_trap); errors++;
        end
        checks++;
        step();
        trap_clear = 1'b0;
        #1;
        if (obs !== ev_fetch()) begin
            $display("FAIL st_timeout_refetch: got %b expected %b", obs, ev_fetch()); errors++;
        end
        checks++;
    endtask

    task automatic test_illegal();
        logic [13:0] e[$];
        e = {ev_fetch(), ev_decode(), ev(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, S_T)};
        opcode = OP_BAD; mem_ready = 1'b1;
        for (int i = 0; i < e.size(); i++) begin
            #1;
            if (obs !== e[i]) begin
                $display("FAIL illegal[%0d]: got %b expected %b", i, obs, e[i]); errors++;
            end
            checks++;
            if (i == 2) trap_clear = 1'b1;
            step();
        end
        trap_clear = 1'b0;
        opcode = OP_R;
        #1;
        if (obs !== ev_fetch() || retired !== exp_ret) begin
            $display("FAIL illegal_clear: got %b/%0d expected %b/%0d", obs, retired, ev_fetch(), exp_ret);
            errors++;
        end
        checks++;
    endtask

    task automatic test_opcode_toggle();
        logic [13:0] e[$];
        logic [6:0]  ops[$];
        e   = {ev_fetch(), ev_decode(), ev(0, 0, 0, 0, 2'b10, 0, 0, 0, 0, 0, S_E),
               ev(0, 1, 0, 0, 2'b10, 0, 0, 0, 1, 0, S_W)};
        ops = {OP_R, OP_BAD, OP_LD, OP_BR};
        for (int i = 0; i < e.size(); i++) begin
            opcode = ops[i];
            #1;
            if (obs !== e[i]) begin
                $display("FAIL opcode_toggle[%0d]: got %b expected %b", i, obs, e[i]); errors++;
            end
            checks++;
            step();
        end
        exp_ret = exp_ret + CNT_W'(1);
        if (retired !== exp_ret) begin
            $display("FAIL opcode_toggle_retired: got %0d expected %0d", retired, exp_ret); errors++;
        end
        checks++;
    endtask

    task automatic test_reset_mid_mem();
        logic [13:0] e[$];
        e = {ev_fetch(), ev_decode(), ev(0, 0, 0, 1, 2'b00, 0, 0, 0, 0, 0, S_E),
             ev(0, 0, 0, 1, 2'b00, 1, 0, 0, 0, 0, S_M)};
        opcode = OP_LD; mem_ready = 1'b0;
        for (int i = 0; i < e.size(); i++) begin
            #1;
            if (obs !== e[i]) begin
                $display("FAIL reset_mid_mem[%0d]: got %b expected %b", i, obs, e[i]); errors++;
            end
            checks++;
            step();
        end
        reset = 1'b1;
        #1;
        if (obs !== 14'd0 || retired !== '0) begin
            $display("FAIL reset_mid_mem_assert: got %b/%0d expected %b/0", obs, retired, 14'd0); errors++;
        end
        checks++;
        step();
        reset = 1'b0;
        exp_ret = '0;
        #1;
        if (obs !== ev_fetch() || retired !== exp_ret) begin
            $display("FAIL reset_mid_mem_release: got %b/%0d expected %b/0", obs, retired, ev_fetch());
            errors++;
        end
        checks++;
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_branch();
        test_load();
        test_itype_store();
        test_store_timeout();
        test_illegal();
        test_opcode_toggle();
        test_reset_mid_mem();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Strobe invariants sampled away from the active edge
    always @(negedge clk) begin
        if (!reset && mem_read && mem_write) begin
            $display("FAIL inv_mem_rw: mem_read=%b mem_write=%b expected not both 1", mem_read, mem_write);
            errors++;
        end
        if (!reset && reg_write && state !== S_W) begin
            $display("FAIL inv_reg_write: reg_write=1 in state %0d expected state 4", state);
            errors++;
        end
    end

endmodule
